// File: rtl/pitch_seg7_formatter.sv
// pitch_seg7_formatter: turns a pitch result (note, octave, cents) into an
// 8-character ASCII frame and streams it to seg7x8, one digit per cycle,
// from digit 7 down to digit 0. One pending request is held so the display
// always settles on the newest result.
//
// state | meaning
// IDLE  | no frame in flight; a note_valid is captured directly
// WRITE | emitting digit pos of the current snapshot, pos counts 7 -> 0
module pitch_seg7_formatter #(
    parameter int unsigned CENTS_TOL = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       note_valid,
    input  logic [3:0] note,
    input  logic [3:0] octave,
    input  logic [7:0] cents,
    output logic       en,
    output logic [2:0] seg7id,
    output logic [7:0] ascii,
    output logic       busy
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t     state, state_next;
    logic [2:0] pos, pos_next;

    logic [3:0] cur_note, cur_note_next;
    logic [3:0] cur_octave, cur_octave_next;
    logic [7:0] cur_cents, cur_cents_next;

    logic       pend_valid, pend_valid_next;
    logic [3:0] pend_note, pend_note_next;
    logic [3:0] pend_octave, pend_octave_next;
    logic [7:0] pend_cents, pend_cents_next;

    logic       en_next, busy_next;
    logic [2:0] seg7id_next;
    logic [7:0] ascii_next;

    // Character shown at digit p for a given snapshot. The magnitude is taken
    // in 8 bits unsigned so -128 becomes 128 without overflow before it is
    // saturated to 99.
    function automatic logic [7:0] frame_char(input logic [3:0] n,
                                              input logic [3:0] o,
                                              input logic [7:0] c,
                                              input logic [2:0] p);
        logic [7:0] abs_c;
        logic [6:0] mag;
        logic [3:0] tens;
        logic [3:0] units;
        logic [7:0] ch;
        abs_c = c[7] ? (8'd0 - c) : c;
        mag   = (abs_c > 8'd99) ? 7'd99 : abs_c[6:0];
        tens  = 4'(mag / 7'd10);
        units = 4'(mag % 7'd10);
        ch    = 8'h20;
        if (n >= 4'd12) begin
            ch = 8'h2D;
        end else begin
            case (p)
                3'd7: begin
                    case (n)
                        4'd0, 4'd1:  ch = "C";
                        4'd2, 4'd3:  ch = "D";
                        4'd4:        ch = "E";
                        4'd5, 4'd6:  ch = "F";
                        4'd7, 4'd8:  ch = "G";
                        4'd9, 4'd10: ch = "A";
                        default:     ch = "B";
                    endcase
                end
                3'd6: ch = (n == 4'd1 || n == 4'd3 || n == 4'd6 ||
                            n == 4'd8 || n == 4'd10) ? "#" : " ";
                3'd5: ch = (o > 4'd9) ? "?" : {4'h3, o};
                3'd4: ch = " ";
                3'd3: ch = (c == 8'd0) ? " " : (c[7] ? "-" : "+");
                3'd2: ch = (tens == 4'd0) ? " " : {4'h3, tens};
                3'd1: ch = {4'h3, units};
                default: ch = ({25'd0, mag} <= CENTS_TOL) ? "=" : " ";
            endcase
        end
        return ch;
    endfunction

    // State, snapshots and registered outputs; reset aborts any frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pos         <= 3'd0;
            cur_note    <= 4'd0;
            cur_octave  <= 4'd0;
            cur_cents   <= 8'd0;
            pend_valid  <= 1'b0;
            pend_note   <= 4'd0;
            pend_octave <= 4'd0;
            pend_cents  <= 8'd0;
            en          <= 1'b0;
            busy        <= 1'b0;
            seg7id      <= 3'd0;
            ascii       <= 8'h20;
        end else begin
            state       <= state_next;
            pos         <= pos_next;
            cur_note    <= cur_note_next;
            cur_octave  <= cur_octave_next;
            cur_cents   <= cur_cents_next;
            pend_valid  <= pend_valid_next;
            pend_note   <= pend_note_next;
            pend_octave <= pend_octave_next;
            pend_cents  <= pend_cents_next;
            en          <= en_next;
            busy        <= busy_next;
            seg7id      <= seg7id_next;
            ascii       <= ascii_next;
        end
    end

    // Next-state: capture, per-digit emission, pending slot and frame chaining.
    always_comb begin
        state_next       = state;
        pos_next         = pos;
        cur_note_next    = cur_note;
        cur_octave_next  = cur_octave;
        cur_cents_next   = cur_cents;
        pend_valid_next  = pend_valid;
        pend_note_next   = pend_note;
        pend_octave_next = pend_octave;
        pend_cents_next  = pend_cents;
        en_next          = 1'b0;
        busy_next        = 1'b0;
        seg7id_next      = seg7id;
        ascii_next       = ascii;
        case (state)
            IDLE: begin
                if (note_valid) begin
                    cur_note_next   = note;
                    cur_octave_next = octave;
                    cur_cents_next  = cents;
                    pos_next        = 3'd7;
                    state_next      = WRITE;
                end
            end
            default: begin
                en_next     = 1'b1;
                busy_next   = 1'b1;
                seg7id_next = pos;
                ascii_next  = frame_char(cur_note, cur_octave, cur_cents, pos);
                pos_next    = pos - 3'd1;
                if (pos == 3'd0) begin
                    // A request on the last digit is newer than anything pending.
                    if (note_valid) begin
                        cur_note_next   = note;
                        cur_octave_next = octave;
                        cur_cents_next  = cents;
                    end else if (pend_valid) begin
                        cur_note_next   = pend_note;
                        cur_octave_next = pend_octave;
                        cur_cents_next  = pend_cents;
                    end else begin
                        state_next = IDLE;
                    end
                    pend_valid_next = 1'b0;
                end else if (note_valid) begin
                    pend_valid_next  = 1'b1;
                    pend_note_next   = note;
                    pend_octave_next = octave;
                    pend_cents_next  = cents;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pitch_seg7_formatter.sv
// Self-checking bench for pitch_seg7_formatter: directed frames, random
// frames against a string-based reference, coalescing and mid-frame reset.
module tb_pitch_seg7_formatter;

    localparam int TOL = 5;

    logic       clk;
    logic       reset;
    logic       note_valid;
    logic [3:0] note;
    logic [3:0] octave;
    logic [7:0] cents;
    logic       en;
    logic [2:0] seg7id;
    logic [7:0] ascii;
    logic       busy;

    int total = 0;
    int bad   = 0;

    pitch_seg7_formatter #(.CENTS_TOL(TOL)) dut (
        .clk(clk), .reset(reset), .note_valid(note_valid), .note(note),
        .octave(octave), .cents(cents), .en(en), .seg7id(seg7id),
        .ascii(ascii), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Reference: frame text as an 8-char string, leftmost char is digit 7.
    function automatic logic [63:0] exp_frame(input int n, input int o, input int c);
        string names;
        string s, oct_s, sign_s, tol_s;
        int m;
        logic [63:0] f;
        names = "C C#D D#E F F#G G#A A#B ";
        if (n >= 12) return {8{8'h2D}};
        m = (c < 0) ? -c : c;
        if (m > 99) m = 99;
        if (o > 9) oct_s = "?"; else oct_s = $sformatf("%0d", o);
        if (c > 0) sign_s = "+"; else if (c < 0) sign_s = "-"; else sign_s = " ";
        if (m <= TOL) tol_s = "="; else tol_s = " ";
        s = $sformatf("%s%s %s%2d%s", names.substr(2*n, 2*n+1), oct_s, sign_s, m, tol_s);
        f = '0;
        for (int i = 0; i < 8; i++) f[8*(7-i) +: 8] = s[i];
        return f;
    endfunction

    // Caller is at a negedge; the inputs are sampled on the following posedge.
    task automatic pulse(input int n, input int o, input int c);
        note       = 4'(n);
        octave     = 4'(o);
        cents      = 8'(c);
        note_valid = 1'b1;
        @(negedge clk);
        note_valid = 1'b0;
    endtask

    task automatic send(input int n, input int o, input int c);
        @(negedge clk);
        pulse(n, o, c);
    endtask

    // Collects one frame: lat = negedges waited for the first strobe,
    // seq_ok = eight contiguous strobes with busy high and ids 7..0.
    task automatic grab_frame(output logic [63:0] got, output int lat, output bit seq_ok);
        bit seen;
        seen   = 1'b0;
        lat    = 0;
        got    = '0;
        seq_ok = 1'b1;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = (en === 1'b1);
        end
        if (!seen) begin
            seq_ok = 1'b0;
            lat    = -1;
            return;
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (!(en === 1'b1 && busy === 1'b1 && seg7id === 3'(7 - k))) seq_ok = 1'b0;
            got[8*(7-k) +: 8] = ascii;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({en, busy, seg7id, ascii} !== {1'b0, 1'b0, 3'd0, 8'h20}) begin
            bad++;
            $display("FAIL reset_state got en=%b busy=%b id=%0d ascii=%h want 0 0 0 20",
                     en, busy, seg7id, ascii);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({en, busy} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset got en=%b busy=%b want 0 0", en, busy);
        end
    endtask

    task automatic test_basic;
        logic [63:0] got;
        logic [63:0] want;
        int lat;
        bit ok;
        want = "A 4 +12 ";
        send(9, 4, 12);
        grab_frame(got, lat, ok);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL basic_frame got %h want %h", got, want);
        end
        total++;
        if (!ok || lat != 1) begin
            bad++;
            $display("FAIL basic_timing got seq_ok=%0d lat=%0d want 1 1", ok, lat);
        end
        @(negedge clk);
        total++;
        if ({en, busy} !== 2'b00) begin
            bad++;
            $display("FAIL basic_busy_len got en=%b busy=%b after 8 strobes want 0 0", en, busy);
        end
    endtask

    task automatic test_cents;
        logic [63:0] got;
        logic [63:0] want;
        int lat;
        bit ok;
        want = "C#3 - 3=";
        send(1, 3, -3);
        grab_frame(got, lat, ok);
        total++;
        if (got !== want || !ok) begin
            bad++;
            $display("FAIL neg_small got %h ok=%0d want %h", got, ok, want);
        end
        want = "C#3   0=";
        send(1, 3, 0);
        grab_frame(got, lat, ok);
        total++;
        if (got !== want || !ok) begin
            bad++;
            $display("FAIL zero_cents got %h ok=%0d want %h", got, ok, want);
        end
    endtask

    task automatic test_extremes;
        logic [63:0] got;
        logic [63:0] want;
        int lat;
        bit ok;
        want = "A 4 -99 ";
        send(9, 4, -128);
        grab_frame(got, lat, ok);
        total++;
        if (got !== want || !ok) begin
            bad++;
            $display("FAIL cents_min got %h want %h", got, want);
        end
        want = "A 4 +99 ";
        send(9, 4, 127);
        grab_frame(got, lat, ok);
        total++;
        if (got !== want || !ok) begin
            bad++;
            $display("FAIL cents_max got %h want %h", got, want);
        end
        want = "C ?   0=";
        send(0, 12, 0);
        grab_frame(got, lat, ok);
        total++;
        if (got !== want || !ok) begin
            bad++;
            $display("FAIL octave_high got %h want %h", got, want);
        end
        want = "B 9 + 6 ";
        send(11, 9, 6);
        grab_frame(got, lat, ok);
        total++;
        if (got !== want || !ok) begin
            bad++;
            $display("FAIL tol_edge got %h want %h", got, want);
        end
    endtask

    task automatic test_no_pitch;
        logic [63:0] got;
        logic [63:0] want;
        int lat;
        bit ok;
        want = "--------";
        send(14, 5, 33);
        grab_frame(got, lat, ok);
        total++;
        if (got !== want || !ok) begin
            bad++;
            $display("FAIL no_pitch got %h want %h", got, want);
        end
    endtask

    task automatic test_random;
        logic [63:0] got;
        logic [7:0] cb;
        int lat, n, o, c;
        bit ok;
        for (int i = 0; i < 24; i++) begin
            n  = int'($urandom_range(0, 15));
            o  = int'($urandom_range(0, 15));
            cb = 8'($urandom);
            c  = int'($signed(cb));
            send(n, o, c);
            grab_frame(got, lat, ok);
            total++;
            if (got !== exp_frame(n, o, c) || !ok || lat != 1) begin
                bad++;
                $display("FAIL random_%0d n=%0d o=%0d c=%0d got %h want %h ok=%0d lat=%0d",
                         i, n, o, c, got, exp_frame(n, o, c), ok, lat);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] got1, got2;
        int lat1, lat2;
        bit ok1, ok2;
        send(2, 4, 5);
        fork
            grab_frame(got1, lat1, ok1);
            begin
                repeat (2) @(negedge clk);
                pulse(4, 2, -20);
                pulse(7, 5, 40);
                pulse(11, 6, -7);
            end
        join
        grab_frame(got2, lat2, ok2);
        total++;
        if (got1 !== exp_frame(2, 4, 5) || !ok1) begin
            bad++;
            $display("FAIL coalesce_first got %h want %h", got1, exp_frame(2, 4, 5));
        end
        total++;
        if (got2 !== exp_frame(11, 6, -7) || !ok2 || lat2 != 1) begin
            bad++;
            $display("FAIL coalesce_newest got %h lat=%0d want %h lat=1",
                     got2, lat2, exp_frame(11, 6, -7));
        end
        @(negedge clk);
        total++;
        if ({en, busy} !== 2'b00) begin
            bad++;
            $display("FAIL coalesce_end got en=%b busy=%b want 0 0", en, busy);
        end

        send(5, 2, 50);
        fork
            grab_frame(got1, lat1, ok1);
            begin
                repeat (7) @(negedge clk);
                pulse(6, 7, -60);
            end
        join
        grab_frame(got2, lat2, ok2);
        total++;
        if (got1 !== exp_frame(5, 2, 50) || !ok1) begin
            bad++;
            $display("FAIL pos0_first got %h want %h", got1, exp_frame(5, 2, 50));
        end
        total++;
        if (got2 !== exp_frame(6, 7, -60) || !ok2 || lat2 != 1) begin
            bad++;
            $display("FAIL pos0_next got %h lat=%0d want %h lat=1",
                     got2, lat2, exp_frame(6, 7, -60));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [63:0] got;
        int lat, strobes, waited;
        bit ok;
        send(9, 4, 12);
        waited = 0;
        while (en !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        total++;
        if (en !== 1'b1 || seg7id !== 3'd4) begin
            bad++;
            $display("FAIL mid_fourth_strobe got en=%b id=%0d want 1 4", en, seg7id);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if ({en, busy, seg7id, ascii} !== {1'b0, 1'b0, 3'd0, 8'h20}) begin
            bad++;
            $display("FAIL mid_reset got en=%b busy=%b id=%0d ascii=%h want 0 0 0 20",
                     en, busy, seg7id, ascii);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en === 1'b1 || busy === 1'b1) strobes++;
        end
        total++;
        if (strobes != 0) begin
            bad++;
            $display("FAIL mid_no_resume got %0d active cycles want 0", strobes);
        end
        send(0, 1, 1);
        grab_frame(got, lat, ok);
        total++;
        if (got !== exp_frame(0, 1, 1) || !ok || lat != 1) begin
            bad++;
            $display("FAIL mid_recover got %h lat=%0d want %h lat=1", got, lat, exp_frame(0, 1, 1));
        end
    endtask

    initial begin
        reset      = 1'b1;
        note_valid = 1'b0;
        note       = 4'd0;
        octave     = 4'd0;
        cents      = 8'd0;
        test_reset();
        test_basic();
        test_cents();
        test_extremes();
        test_no_pitch();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pitch_seg7_formatter.md
# pitch_seg7_formatter

Upstream feeder for the 8-digit seven-segment driver `seg7x8`. It takes a detected pitch result (note class, octave, cents deviation) and converts it to an 8-character ASCII frame. It writes the frame to the display one character per cycle, using the driver's write-strobe interface (`en`, `seg7id`, `ascii`). It holds one pending request, so the display always converges to the most recent pitch result without the detector having to stall.

## Interface
- `CENTS_TOL`, default 5: magnitude (in cents) at or below which the in-tune marker is shown.
- `clk`  in  1: system clock (100 MHz); all state is updated on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `note_valid`  in  1: single-cycle request strobe; samples `note`, `octave` and `cents`.
- `note`  in  4: note class. 0=C, 1=C#, 2=D, 3=D#, 4=E, 5=F, 6=F#, 7=G, 8=G#, 9=A, 10=A#, 11=B. 12–15 mean "no pitch".
- `octave`  in  4: octave number.
- `cents`  in  8: signed two's-complement deviation from the nominal note.
- `en`  out  1: one-cycle write strobe to `seg7x8`.
- `seg7id`  out  3: digit index being written; 7 is the leftmost digit.
- `ascii`  out  8: character being written.
- `busy`  out  1: high while a frame is being written.

## Operation
- States:
  - IDLE.
  - WRITE, with a 3-bit position counter `pos` running 7→0.
- Each request is snapshotted at capture. Later changes on the inputs do not affect a frame in flight.
- Frame layout, by digit id:
  - 7: note letter, 'C','D','E','F','G','A','B'.
  - 6: '#' for sharps, otherwise ' '.
  - 5: octave '0'–'9'; '?' if octave > 9.
  - 4: ' '.
  - 3: sign. '+' if cents > 0, '-' if cents < 0, ' ' if cents = 0.
  - 2: tens digit of the magnitude; ' ' if it is 0.
  - 1: units digit of the magnitude (always a digit).
  - 0: '=' if magnitude ≤ CENTS_TOL, otherwise ' '.
- Magnitude is |cents| saturated to 99. Both -128 and 127 give 99, with no overflow.
- If `note` ≥ 12, all 8 characters are '-' (0x2D).
- IDLE and `note_valid`=1: capture the snapshot and enter WRITE with pos=7.
- WRITE: each cycle emits one character, then decrements `pos`.
  - After pos=0 with no pending request, return to IDLE.
  - After pos=0 with a request pending, load the pending snapshot, clear pending, and restart at pos=7 with no gap.
- `note_valid` during WRITE, including on the pos=0 cycle, stores the request in the single pending slot.
  - A newer request overwrites an older pending one. Only the newest is kept.
  - It never alters the frame in flight.
- Reset:
  - `en`=0, `seg7id`=0, `ascii`=0x20, `busy`=0.
  - Pending is cleared and the state is IDLE.
  - Reset asserted mid-frame aborts the frame immediately. No further `en` is issued, and the partial frame is not resumed.

## Timing
- All outputs are registered.
- A request captured at edge N produces `en`=1 in cycles N+1 through N+8.
  - `seg7id` runs 7,6,…,0 and `ascii` carries the matching character.
- `busy`=1 in cycles N+1 through N+8, and falls in N+9 unless a request is pending.
- A pending request continues the stream directly: `en` stays high for 16 consecutive cycles. The second frame starts at N+9 with `seg7id`=7.
- `en`=0 whenever `busy`=0. `seg7id` and `ascii` hold their last values while `en`=0.
- A request arriving one cycle after the IDLE return (N+9) is captured and drives its first write at N+10.
- Throughput: at most one frame per 8 cycles. Requests faster than that are coalesced to the newest.

## Test plan
- Reset, then request `note`=9, `octave`=4, `cents`=+12 → 8 strobes, ids 7..0, ascii "A", " ", "4", " ", "+", "1", "2", " ". `busy` is high for exactly 8 cycles.
- `note`=1, `octave`=3, `cents`=-3 → "C", "#", "3", " ", "-", " ", "3", "=". Then `cents`=0 → digit 3 is ' ', digit 1 is '0', digit 0 is '='.
- `cents`=-128, then `cents`=127 → digit 3 is '-' then '+'; digits 2..1 are "99" in both cases. Separately, `octave`=12 → digit 5 is '?'.
- `note`=14 → eight strobes of 0x2D.
- Send three requests (values A, B, C) during one frame → that frame finishes unchanged, then a back-to-back frame shows C only (16 consecutive `en`). Also, a request on the pos=0 cycle → next frame starts with no gap.
- Assert `reset` at the 4th strobe → in the same cycle `en`=0, `busy`=0, `ascii`=0x20, and no further strobes occur until a new request.
